// File: rtl/frame_tx_arbiter.sv
// Two-source frame arbiter: latches per-source frame requests, grants them round-robin,
// announces each frame with a sync pulse and merges the granted source onto one stream.
module frame_tx_arbiter #(
  parameter int TIMEOUT = 4096,
  parameter int GAP_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_a,
  input  logic        i_req_b,
  input  logic [15:0] i_size_a,
  input  logic [15:0] i_size_b,
  input  logic [31:0] i_data_a,
  input  logic [31:0] i_data_b,
  input  logic        i_vld_a,
  input  logic        i_vld_b,
  output logic        o_rdy_a,
  output logic        o_rdy_b,
  output logic        o_sync,
  output logic [15:0] o_size,
  output logic [31:0] o_data,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_ovf_cnt
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ANNOUNCE, S_STREAM, S_GAP} state_t;

  state_t           state_q, state_d;
  logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [15:0]      size_a_q, size_a_d, size_b_q, size_b_d;
  logic             last_b_q, last_b_d;
  logic             sel_b_q, sel_b_d;
  logic [15:0]      osize_q, osize_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [7:0]       ovf_q, ovf_d;

  logic             grant_a, grant_b, ovf_a, ovf_b, sel_vld, xfer, timeout;
  logic [15:0]      gsize;
  logic [8:0]       ovf_sum;

  assign sel_vld = sel_b_q ? i_vld_b : i_vld_a;

  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    sel_b_d   = sel_b_q;
    osize_d   = osize_q;
    cnt_d     = cnt_q;
    wdog_d    = '0;
    gap_d     = '0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    xfer      = 1'b0;
    timeout   = 1'b0;
    gsize     = '0;

    case (state_q)
      S_IDLE: begin
        if (pend_a_q && (!pend_b_q || last_b_q)) grant_a = 1'b1;
        else if (pend_b_q)                       grant_b = 1'b1;
        if (grant_a || grant_b) begin
          gsize    = grant_b ? size_b_q : size_a_q;
          last_b_d = grant_b;
          sel_b_d  = grant_b;
          if (gsize == 16'd0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_ANNOUNCE;
            osize_d = gsize;
            cnt_d   = gsize;
          end
        end
      end
      S_ANNOUNCE: state_d = S_STREAM;
      S_STREAM: begin
        xfer = sel_vld & i_rdy;
        if (xfer) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_GAP;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_GAP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      // GAP occupies GAP_CYC hold cycles plus the cycle that returns to IDLE
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC)) state_d = S_IDLE;
        else                       gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // a new request beats a same-cycle grant clear and is not an overrun
    pend_a_d = i_req_a | (pend_a_q & ~grant_a);
    pend_b_d = i_req_b | (pend_b_q & ~grant_b);
    ovf_a    = i_req_a & pend_a_q & ~grant_a;
    ovf_b    = i_req_b & pend_b_q & ~grant_b;
    size_a_d = i_req_a ? i_size_a : size_a_q;
    size_b_d = i_req_b ? i_size_b : size_b_q;
    ovf_sum  = {1'b0, ovf_q} + 9'(ovf_a) + 9'(ovf_b);
    ovf_d    = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      size_a_q <= '0;
      size_b_q <= '0;
      last_b_q <= 1'b1;
      sel_b_q  <= 1'b0;
      osize_q  <= '0;
      cnt_q    <= '0;
      wdog_q   <= '0;
      gap_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      size_a_q <= size_a_d;
      size_b_q <= size_b_d;
      last_b_q <= last_b_d;
      sel_b_q  <= sel_b_d;
      osize_q  <= osize_d;
      cnt_q    <= cnt_d;
      wdog_q   <= wdog_d;
      gap_q    <= gap_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_sync    = (state_q == S_ANNOUNCE);
  assign o_size    = osize_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_vld     = (state_q == S_STREAM) & sel_vld;
  assign o_rdy_a   = (state_q == S_STREAM) & ~sel_b_q & i_rdy;
  assign o_rdy_b   = (state_q == S_STREAM) &  sel_b_q & i_rdy;
  assign o_data    = (state_q == S_STREAM) ? (sel_b_q ? i_data_b : i_data_a) : '0;
  assign o_timeout = timeout;
  assign o_ovf_cnt = ovf_q;

endmodule
